// File: rtl/hazard_light_gen.sv
// Hazard-light pattern generator: steps a 3-LED wind pattern every TICK_DIV enabled
// clocks and emits a one-cycle step strobe alongside each new frame.
module hazard_light_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] mode,
    output logic [2:0] leds,
    output logic       step
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

    typedef enum logic [3:0] {
        OFF    = 4'd0,
        CALM_A = 4'd1,
        CALM_B = 4'd2,
        RL0    = 4'd3,
        RL1    = 4'd4,
        RL2    = 4'd5,
        LR0    = 4'd6,
        LR1    = 4'd7,
        LR2    = 4'd8
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic          tick;
    logic          state_legal;

    assign tick        = en && (cnt == CNT_MAX);
    assign state_legal = (4'(state) <= 4'(LR2));

    // Prescaler holds (rather than clears) while en is low, so gating stretches the frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= OFF;
            step  <= 1'b0;
        end else begin
            state <= state_next;
            step  <= tick;
        end
    end

    // A mode change always lands on the first frame of the new family.
    always_comb begin
        state_next = state;
        if (tick) begin
            if (!state_legal) begin
                state_next = OFF;
            end else begin
                case (mode)
                    2'b00: state_next = (state == CALM_A) ? CALM_B : CALM_A;
                    2'b01: begin
                        case (state)
                            RL0:     state_next = RL1;
                            RL1:     state_next = RL2;
                            default: state_next = RL0;
                        endcase
                    end
                    2'b10: begin
                        case (state)
                            LR0:     state_next = LR1;
                            LR1:     state_next = LR2;
                            default: state_next = LR0;
                        endcase
                    end
                    default: state_next = OFF;
                endcase
            end
        end
    end

    always_comb begin
        leds = 3'b000;
        case (state)
            CALM_A:  leds = 3'b101;
            CALM_B:  leds = 3'b010;
            RL0:     leds = 3'b001;
            RL1:     leds = 3'b010;
            RL2:     leds = 3'b100;
            LR0:     leds = 3'b100;
            LR1:     leds = 3'b010;
            LR2:     leds = 3'b001;
            default: leds = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_hazard_light_gen.sv
// Bench for hazard_light_gen: a TICK_DIV=4 and a TICK_DIV=1 instance share stimulus and
// are checked every cycle against a frame-level model, plus literal frame expectations.
module tb_hazard_light_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [1:0] mode;
    logic [2:0] leds0, leds1;
    logic       step0, step1;

    int n_tests = 0;
    int n_fail  = 0;
    bit checking = 1'b0;

    hazard_light_gen #(.TICK_DIV(4)) dut4 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .leds(leds0), .step(step0)
    );

    hazard_light_gen #(.TICK_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .leds(leds1), .step(step1)
    );

    always #5 clk = ~clk;

    // Model: a family (the mode last applied) and a position within that family's frame list.
    int         div[2] = '{4, 1};
    int         m_cnt[2] = '{0, 0};
    int         m_fam[2] = '{3, 3};
    int         m_pos[2] = '{0, 0};
    logic [2:0] m_leds[2] = '{3'b000, 3'b000};
    logic       m_step[2] = '{1'b0, 1'b0};

    function automatic logic [2:0] pattern(int fam, int pos);
        logic [2:0] calm[2] = '{3'b101, 3'b010};
        logic [2:0] rl[3]   = '{3'b001, 3'b010, 3'b100};
        logic [2:0] lr[3]   = '{3'b100, 3'b010, 3'b001};
        case (fam)
            0:       return calm[pos];
            1:       return rl[pos];
            2:       return lr[pos];
            default: return 3'b000;
        endcase
    endfunction

    function automatic int fam_len(int fam);
        case (fam)
            0:       return 2;
            1, 2:    return 3;
            default: return 1;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                m_cnt[i]  = 0;
                m_fam[i]  = 3;
                m_pos[i]  = 0;
                m_leds[i] = 3'b000;
                m_step[i] = 1'b0;
            end else begin
                m_step[i] = 1'b0;
                if (en) begin
                    if (m_cnt[i] == div[i] - 1) begin
                        m_cnt[i]  = 0;
                        m_step[i] = 1'b1;
                        if (int'(mode) == m_fam[i]) begin
                            m_pos[i] = (m_pos[i] + 1) % fam_len(m_fam[i]);
                        end else begin
                            m_fam[i] = int'(mode);
                            m_pos[i] = 0;
                        end
                        m_leds[i] = pattern(m_fam[i], m_pos[i]);
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end
            end
        end
    end

    task automatic checkOutput(string name, logic [2:0] got_l, logic got_s,
                               logic [2:0] exp_l, logic exp_s);
        n_tests++;
        if (got_l !== exp_l || got_s !== exp_s) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: leds=%b step=%b, expected leds=%b step=%b",
                     name, $time, got_l, got_s, exp_l, exp_s);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("model_div4", leds0, step0, m_leds[0], m_step[0]);
            checkOutput("model_div1", leds1, step1, m_leds[1], m_step[1]);
        end
    end

    task automatic applyStimulus(logic new_en, logic [1:0] new_mode);
        en   = new_en;
        mode = new_mode;
    endtask

    task automatic waitEdge(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(1'b0, 2'b00);
        repeat (3) @(negedge clk);
        checkOutput("reset_div4", leds0, step0, 3'b000, 1'b0);
        checkOutput("reset_div1", leds1, step1, 3'b000, 1'b0);
        checking = 1'b1;

        reset = 1'b1;
        applyStimulus(1'b1, 2'b00);
        waitEdge(1);
        checkOutput("calm_e1_div4", leds0, step0, 3'b000, 1'b0);
        checkOutput("calm_e1_div1", leds1, step1, 3'b101, 1'b1);
        waitEdge(1);
        checkOutput("calm_e2_div1", leds1, step1, 3'b010, 1'b1);
        waitEdge(1);
        checkOutput("calm_e3_div4", leds0, step0, 3'b000, 1'b0);
        waitEdge(1);
        checkOutput("calm_e4", leds0, step0, 3'b101, 1'b1);
        waitEdge(3);
        checkOutput("calm_e7", leds0, step0, 3'b101, 1'b0);
        waitEdge(1);
        checkOutput("calm_e8", leds0, step0, 3'b010, 1'b1);
        waitEdge(4);
        checkOutput("calm_e12", leds0, step0, 3'b101, 1'b1);

        // Right-to-left sweep with a brief mode glitch that never reaches a tick edge.
        applyStimulus(1'b1, 2'b01);
        waitEdge(4);
        checkOutput("rl_first", leds0, step0, 3'b001, 1'b1);
        waitEdge(1);
        applyStimulus(1'b1, 2'b10);
        waitEdge(1);
        applyStimulus(1'b1, 2'b01);
        waitEdge(2);
        checkOutput("rl_second", leds0, step0, 3'b010, 1'b1);
        waitEdge(4);
        checkOutput("rl_third", leds0, step0, 3'b100, 1'b1);
        waitEdge(4);
        checkOutput("rl_wrap", leds0, step0, 3'b001, 1'b1);

        applyStimulus(1'b1, 2'b10);
        waitEdge(4);
        checkOutput("lr_first", leds0, step0, 3'b100, 1'b1);
        waitEdge(4);
        checkOutput("lr_second", leds0, step0, 3'b010, 1'b1);
        applyStimulus(1'b1, 2'b01);
        waitEdge(4);
        checkOutput("lr_to_rl0", leds0, step0, 3'b001, 1'b1);
        applyStimulus(1'b1, 2'b11);
        waitEdge(4);
        checkOutput("off_entry", leds0, step0, 3'b000, 1'b1);
        waitEdge(4);
        checkOutput("off_to_off", leds0, step0, 3'b000, 1'b1);

        // Enable gating: en drops for 5 edges with the count at 2; frame becomes 9 cycles.
        applyStimulus(1'b1, 2'b00);
        waitEdge(2);
        applyStimulus(1'b0, 2'b00);
        for (int i = 0; i < 5; i++) begin
            waitEdge(1);
            checkOutput("gated_div4", leds0, step0, 3'b000, 1'b0);
            checkOutput("gated_div1_step", 3'b000, step1, 3'b000, 1'b0);
        end
        applyStimulus(1'b1, 2'b00);
        waitEdge(1);
        checkOutput("gate_resume", leds0, step0, 3'b000, 1'b0);
        waitEdge(1);
        checkOutput("gate_tick", leds0, step0, 3'b101, 1'b1);

        // en falls exactly where the count would reach its last value: tick deferred by one.
        waitEdge(3);
        applyStimulus(1'b0, 2'b00);
        waitEdge(1);
        checkOutput("defer_no_tick", leds0, step0, 3'b101, 1'b0);
        applyStimulus(1'b1, 2'b00);
        waitEdge(1);
        checkOutput("defer_tick", leds0, step0, 3'b010, 1'b1);

        applyStimulus(1'b1, 2'b01);
        waitEdge(12);
        checkOutput("pre_reset", leds0, step0, 3'b100, 1'b1);
        waitEdge(2);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_div4", leds0, step0, 3'b000, 1'b0);
        checkOutput("async_div1", leds1, step1, 3'b000, 1'b0);
        waitEdge(1);
        reset = 1'b1;
        waitEdge(1);
        checkOutput("rel_e1_div1", leds1, step1, 3'b001, 1'b1);
        waitEdge(2);
        checkOutput("rel_e3", leds0, step0, 3'b000, 1'b0);
        waitEdge(1);
        checkOutput("rel_e4", leds0, step0, 3'b001, 1'b1);

        applyStimulus(1'b0, 2'b00);
        waitEdge(3);
        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
